// File: rtl/sysid_regs_v2.sv
// System-ID peripheral: Avalon-MM slave with fixed read latency 1 exposing ID, build
// timestamp, an uptime counter with atomic LO-then-HI read, control/status and scratch words.
module sysid_regs_v2 #(
  parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int          UPTIME_WIDTH  = 48,
  parameter int          NUM_SCRATCH   = 2,
  parameter int          ADDR_WIDTH    = 3,
  // Counter value loaded by reset; leave at 0 for normal use.
  parameter logic [63:0] UPTIME_PRESET = 64'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [3:0]            byteenable,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  output logic                  irq
);

  localparam int HW  = UPTIME_WIDTH - 32;
  localparam int SIW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [UPTIME_WIDTH-1:0] CNT_INIT = UPTIME_PRESET[UPTIME_WIDTH-1:0];

  logic [UPTIME_WIDTH-1:0] cnt_q, cnt_d;
  logic [HW-1:0]           hi_q, hi_d;
  logic                    freeze_q, freeze_d;
  logic                    ie_q, ie_d;
  logic                    sts_q, sts_d;
  logic [31:0]             scratch_q [NUM_SCRATCH];
  logic [31:0]             scratch_d [NUM_SCRATCH];
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  logic [31:0]    addr_w;
  logic           rd_acc;
  logic           wr_ctrl;
  logic           clear;
  logic           wrap;
  logic           scr_hit;
  logic [SIW-1:0] scr_idx;
  logic [31:0]    rd_mux;

  assign addr_w  = 32'(address);
  // A write in the same cycle as a read takes the bus; the read is dropped.
  assign rd_acc  = read & ~write;
  assign wr_ctrl = write & (addr_w == 32'd4);
  assign clear   = wr_ctrl & writedata[1];
  assign wrap    = ~freeze_q & ~clear & (&cnt_q);
  assign scr_hit = (addr_w >= 32'd5) && (addr_w < 32'(5 + NUM_SCRATCH));
  assign scr_idx = SIW'(addr_w - 32'd5);

  always_comb begin
    rd_mux = '0;
    case (addr_w)
      32'd0:   rd_mux = ID_VALUE;
      32'd1:   rd_mux = TIMESTAMP;
      32'd2:   rd_mux = cnt_q[31:0];
      32'd3:   rd_mux = 32'(hi_q);
      32'd4:   rd_mux = {23'd0, sts_q, 5'd0, ie_q, 1'b0, freeze_q};
      default: if (scr_hit) rd_mux = scratch_q[scr_idx];
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    freeze_d  = freeze_q;
    ie_d      = ie_q;
    sts_d     = sts_q;
    scratch_d = scratch_q;
    rdata_d   = rdata_q;
    rvalid_d  = rd_acc;

    if (clear)
      cnt_d = '0;
    else if (!freeze_q)
      cnt_d = cnt_q + UPTIME_WIDTH'(1);

    if (wr_ctrl) begin
      freeze_d = writedata[0];
      ie_d     = writedata[2];
    end

    // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
    if (wrap)
      sts_d = 1'b1;
    else if (wr_ctrl && writedata[8])
      sts_d = 1'b0;

    if (rd_acc) begin
      rdata_d = rd_mux;
      if (addr_w == 32'd2)
        hi_d = cnt_q[UPTIME_WIDTH-1:32];
    end

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (write && scr_hit && (scr_idx == SIW'(i)) && byteenable[b])
          scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= CNT_INIT;
      hi_q      <= '0;
      freeze_q  <= 1'b0;
      ie_q      <= 1'b0;
      sts_q     <= 1'b0;
      scratch_q <= '{default: '0};
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      freeze_q  <= freeze_d;
      ie_q      <= ie_d;
      sts_q     <= sts_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign irq           = sts_q & ie_q;

endmodule

// File: tb/tb_sysid_regs_v2.sv
// Scoreboard bench for sysid_regs_v2: a default 48-bit instance and a 33-bit instance
// preset just below its wrap point; reads queue their expected data for a negedge monitor.
module tb_sysid_regs_v2;

  localparam logic [31:0] ID_V = 32'h5EED_1D01;
  localparam logic [31:0] TS_V = 32'h6543_2100;
  localparam int          NPRE = 40;
  localparam logic [63:0] PRE_B = 64'h1_FFFF_FFFF - 64'(NPRE);

  logic        clock;
  logic        reset;
  logic [2:0]  addr;
  logic        rd, wr, sel_b;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        rd_av, wr_av, rd_bv, wr_bv;
  logic [31:0] rdata_a, rdata_b;
  logic        rdv_a, rdv_b, irq_a, irq_b;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  logic [31:0] caps [2];

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          due;
    bit          on_b;
    int          cap;
    string       nm;
  } exp_t;
  exp_t sb[$];

  assign rd_av = rd & ~sel_b;
  assign wr_av = wr & ~sel_b;
  assign rd_bv = rd & sel_b;
  assign wr_bv = wr & sel_b;

  sysid_regs_v2 #(.ID_VALUE(ID_V), .TIMESTAMP(TS_V)) dut_a (
    .clock(clock), .reset(reset), .address(addr), .read(rd_av), .write(wr_av),
    .byteenable(be), .writedata(wd), .readdata(rdata_a), .readdatavalid(rdv_a), .irq(irq_a));

  sysid_regs_v2 #(.ID_VALUE(ID_V), .TIMESTAMP(TS_V), .UPTIME_WIDTH(33),
                  .UPTIME_PRESET(PRE_B)) dut_b (
    .clock(clock), .reset(reset), .address(addr), .read(rd_bv), .write(wr_bv),
    .byteenable(be), .writedata(wd), .readdata(rdata_b), .readdatavalid(rdv_b), .irq(irq_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  // Monitor: every valid must match the oldest queued expectation, on time.
  initial begin
    exp_t        e;
    logic [31:0] got;
    logic        ok;
    forever begin
      @(negedge clock);
      if (rdv_a === 1'b1 || rdv_b === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid valid_a=%0b valid_b=%0b", rdv_a, rdv_b);
        end else begin
          e   = sb.pop_front();
          got = e.on_b ? rdata_b : rdata_a;
          ok  = (got >= e.lo) && (got <= e.hi) && (ncyc == e.due) &&
                ((e.on_b ? rdv_b : rdv_a) === 1'b1) && !(rdv_a === 1'b1 && rdv_b === 1'b1);
          if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s got=%h at cycle %0d, want [%h..%h] at cycle %0d",
                     e.nm, got, ncyc, e.lo, e.hi, e.due);
          end
          if (e.cap >= 0) caps[e.cap] = got;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout n_vec=%0d", n_vec);
    $fatal(1, "bench timeout");
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, expv);
    end
  endtask

  task automatic idle(int n);
    rd = 1'b0; wr = 1'b0; be = 4'h0; wd = '0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_write(bit b, int a, logic [3:0] bev, logic [31:0] d);
    sel_b = b; addr = 3'(a); wr = 1'b1; rd = 1'b0; be = bev; wd = d;
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic do_read(bit b, int a, logic [31:0] lo, logic [31:0] hi, string nm, int cap = -1);
    exp_t e;
    sel_b = b; addr = 3'(a); rd = 1'b1; wr = 1'b0;
    e.lo = lo; e.hi = hi; e.due = ncyc + 1; e.on_b = b; e.cap = cap; e.nm = nm;
    sb.push_back(e);
    @(negedge clock);
    rd = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; sel_b = 1'b0; addr = '0; be = '0; wd = '0;
    repeat (3) @(negedge clock);
    chk("rst_valid_a", 32'(rdv_a), 32'd0);
    chk("rst_valid_b", 32'(rdv_b), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_irq_a", 32'(irq_a), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 33-bit instance: read LO at all-ones, then HI after the wrap.
    guard = 0;
    while (ncyc != NPRE && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    chk("b_align_cycle", 32'(ncyc), 32'(NPRE));
    do_read(1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b_lo_allones");
    do_read(1, 3, 32'd1, 32'd1, "b_hi_snapshot");
    chk("b_irq_ie_off", 32'(irq_b), 32'd0);
    do_read(1, 4, 32'h100, 32'h100, "b_ctrl_wrap_sts");
    do_write(1, 4, 4'hF, 32'h4);
    chk("b_irq_ie_on", 32'(irq_b), 32'd1);
    do_write(1, 4, 4'hF, 32'h104);
    chk("b_irq_w1c", 32'(irq_b), 32'd0);
    do_read(1, 4, 32'h4, 32'h4, "b_ctrl_after_w1c");

    // ID/timestamp back to back, reset contents.
    do_read(0, 0, ID_V, ID_V, "id");
    do_read(0, 1, TS_V, TS_V, "timestamp");
    do_read(0, 4, 32'd0, 32'd0, "ctrl_reset");
    do_read(0, 5, 32'd0, 32'd0, "scr0_reset");

    // Scratch byte lanes, unmapped and read-only addresses.
    do_write(0, 5, 4'b0101, 32'hDEAD_BEEF);
    do_read(0, 5, 32'h00AD_00EF, 32'h00AD_00EF, "scr0_be0101");
    do_write(0, 5, 4'b0000, 32'hFFFF_FFFF);
    do_read(0, 5, 32'h00AD_00EF, 32'h00AD_00EF, "scr0_be0000");
    do_write(0, 6, 4'hF, 32'h1234_5678);
    do_write(0, 6, 4'b1000, 32'hAB00_0000);
    do_read(0, 6, 32'hAB34_5678, 32'hAB34_5678, "scr1_be1000");
    idle(1);
    chk("rdata_hold", rdata_a, 32'hAB34_5678);
    do_write(0, 0, 4'hF, 32'hFFFF_FFFF);
    do_write(0, 7, 4'hF, 32'hFFFF_FFFF);
    do_read(0, 0, ID_V, ID_V, "id_after_write");
    do_read(0, 7, 32'd0, 32'd0, "unmapped");
    do_read(0, 3, 32'd0, 32'd0, "hi_no_snapshot");

    // CTRL: all ones sets FREEZE+IE, CLEAR self-clears, W1C on clear flag.
    do_write(0, 4, 4'h0, 32'hFFFF_FFFF);
    do_read(0, 4, 32'h5, 32'h5, "ctrl_bits");
    chk("irq_no_sts", 32'(irq_a), 32'd0);
    do_read(0, 2, 32'd0, 32'd0, "lo_frozen_cleared");
    do_read(0, 3, 32'd0, 32'd0, "hi_frozen_cleared");

    // Run 100 cycles, atomic LO/HI and consecutive LO reads.
    do_write(0, 4, 4'hF, 32'h0);
    idle(100);
    do_read(0, 2, 32'd100, 32'd102, "lo_run100");
    do_read(0, 3, 32'd0, 32'd0, "hi_run100");
    do_read(0, 2, 32'd0, 32'hFFFF_FFFF, "lo_cons0", 0);
    do_read(0, 2, 32'd0, 32'hFFFF_FFFF, "lo_cons1", 1);
    idle(2);
    chk("lo_consecutive_delta", caps[1] - caps[0], 32'd1);

    // CLEAR while running wins over the increment.
    do_write(0, 4, 4'hF, 32'h2);
    do_read(0, 2, 32'd0, 32'd0, "lo_after_clear");
    do_read(0, 4, 32'd0, 32'd0, "ctrl_clear_reads0");

    // Read and write in the same cycle: write lands, no valid.
    sel_b = 1'b0; addr = 3'd6; rd = 1'b1; wr = 1'b1; be = 4'hF; wd = 32'hCAFE_F00D;
    @(negedge clock);
    rd = 1'b0; wr = 1'b0;
    chk("rw_no_valid", 32'(rdv_a), 32'd0);
    do_read(0, 6, 32'hCAFE_F00D, 32'hCAFE_F00D, "scr1_rw_same_cycle");

    // Reset together with a read: the read is dropped and state returns to zero.
    do_write(0, 4, 4'hF, 32'h4);
    sel_b = 1'b0; addr = 3'd0; rd = 1'b1; reset = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    chk("rst_drops_read", 32'(rdv_a), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_read(0, 2, 32'd1, 32'd1, "lo_after_reset");
    do_read(0, 5, 32'd0, 32'd0, "scr0_after_reset");
    do_read(0, 6, 32'd0, 32'd0, "scr1_after_reset");
    do_read(0, 4, 32'd0, 32'd0, "ctrl_after_reset");
    do_read(0, 3, 32'd0, 32'd0, "hi_after_reset");
    chk("irq_after_reset", 32'(irq_a), 32'd0);

    idle(3);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk("pending_reads", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
